mem_wb_pipe: RTL

- Writer side of the execute-stage forwarding interface.
- Registers execute results into the EX/MEM stage, performs the data-memory access with a ready handshake, and registers the write-back value into MEM/WB.
- Drives the bypass sources `result_EXMEM`, `rd_EXMEM`, `regWrite_EXMEM`, `rd_MEMWB`, `regWrite_MEMWB` and `valueToWB`.
- Also produces the load-use stall and memory-stall signals that freeze upstream stages.

---
 rtl/mem_wb_pipe_pkg.sv | 11 +
 rtl/mem_wb_pipe_if.sv | 12 +
 rtl/mem_wb_pipe_mem_access_fsm.sv | 60 ++++++
 rtl/mem_wb_pipe.sv | 96 +++++++++
 4 files changed

// File: rtl/mem_wb_pipe_pkg.sv
// mem_wb_pipe_pkg: shared widths, register-zero constant and memory-access FSM encoding.
package mem_wb_pipe_pkg;
    localparam int REG_W = 5;
    localparam int DATA_W = 32;
    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        ABORT = 2'd2
    } memState_t;
endpackage

// File: rtl/mem_wb_pipe_if.sv
// mem_wb_pipe_if: data-memory bus between the MEM stage (master) and the memory (slave).
interface mem_wb_pipe_if;
    import mem_wb_pipe_pkg::*;
    logic [DATA_W-1:0] memAddr;
    logic [DATA_W-1:0] memWData;
    logic [DATA_W-1:0] memReadData;
    logic              memRe;
    logic              memWe;
    logic              memReady;
    modport master (output memAddr, memWData, memRe, memWe, input memReady, memReadData);
    modport slave (input memAddr, memWData, memRe, memWe, output memReady, memReadData);
endinterface

// File: rtl/mem_wb_pipe_mem_access_fsm.sv
// mem_access_fsm: data-memory handshake with wait counting, timeout abort and stall generation.
module mem_access_fsm
    import mem_wb_pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic rdReq,
    input  logic wrReq,
    input  logic memReady,
    output logic memStall,
    output logic memRe,
    output logic memWe,
    output logic memErr,
    output logic abort
);
    memState_t  state, stateNext;
    logic [7:0] cnt, cntNext;
    logic       memOp;
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end
    always_comb begin
        memOp     = rdReq | wrReq;
        stateNext = state;
        cntNext   = cnt;
        case (state)
            IDLE: if (memOp && !memReady) begin
                stateNext = WAIT;
                cntNext   = 8'd1;
            end
            WAIT: if (memReady) begin
                stateNext = IDLE;
                cntNext   = 8'd0;
            end else if (cnt == 8'(MEM_TIMEOUT - 1)) begin
                stateNext = ABORT;
                cntNext   = 8'd0;
            end else begin
                cntNext = cnt + 8'd1;
            end
            default: begin
                stateNext = IDLE;
                cntNext   = 8'd0;
            end
        endcase
        abort = state == ABORT;
        // outputs are gated by reset so a sync reset mid-access shows a quiet bus at once
        memStall = ~reset & memOp & ~memReady & ~abort;
        memRe    = ~reset & rdReq & ~abort;
        memWe    = ~reset & wrReq & ~abort;
        memErr   = ~reset & abort;
    end
endmodule

// File: rtl/mem_wb_pipe.sv
// mem_wb_pipe: EX/MEM and MEM/WB pipeline registers, data-memory access and stall generation.
// Optional stall counter output enabled by MEM_WB_STALL_CNT_EN.
module mem_wb_pipe
    import mem_wb_pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_IDEX,
    input  logic [DATA_W-1:0] result,
    input  logic [DATA_W-1:0] storeData,
    input  logic [REG_W-1:0]  rd_IDEX,
    input  logic              regWrite_IDEX,
    input  logic              memRead_IDEX,
    input  logic              memWrite_IDEX,
    input  logic              memToReg_IDEX,
    input  logic [REG_W-1:0]  rs_IFID,
    input  logic [REG_W-1:0]  rt_IFID,
    input  logic              flush,
    mem_wb_pipe_if.master     mem,
    output logic [DATA_W-1:0] result_EXMEM,
    output logic [REG_W-1:0]  rd_EXMEM,
    output logic              regWrite_EXMEM,
    output logic [REG_W-1:0]  rd_MEMWB,
    output logic              regWrite_MEMWB,
    output logic [DATA_W-1:0] valueToWB,
    output logic              memStall,
    output logic              loadUseStall,
    output logic              memErr
`ifdef MEM_WB_STALL_CNT_EN
    ,
    output logic [DATA_W-1:0] stallCount
`endif
);
    logic              valid_EXMEM, memRead_EXMEM, memWrite_EXMEM, memToReg_EXMEM;
    logic              validIn, abort;
    logic [DATA_W-1:0] storeData_EXMEM;
    assign validIn      = valid_IDEX & ~flush;
    assign mem.memAddr  = result_EXMEM;
    assign mem.memWData = storeData_EXMEM;
    assign loadUseStall = ~reset & ~memStall & valid_IDEX & memRead_IDEX & (rd_IDEX != REG_ZERO)
                        & ((rd_IDEX == rs_IFID) | (rd_IDEX == rt_IFID));
    mem_access_fsm #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_fsm (
        .clk      (clk),
        .reset    (reset),
        .rdReq    (valid_EXMEM & memRead_EXMEM),
        .wrReq    (valid_EXMEM & memWrite_EXMEM),
        .memReady (mem.memReady),
        .memStall (memStall),
        .memRe    (mem.memRe),
        .memWe    (mem.memWe),
        .memErr   (memErr),
        .abort    (abort)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_EXMEM     <= 1'b0;
            result_EXMEM    <= '0;
            storeData_EXMEM <= '0;
            rd_EXMEM        <= '0;
            regWrite_EXMEM  <= 1'b0;
            memRead_EXMEM   <= 1'b0;
            memWrite_EXMEM  <= 1'b0;
            memToReg_EXMEM  <= 1'b0;
            rd_MEMWB        <= '0;
            regWrite_MEMWB  <= 1'b0;
            valueToWB       <= '0;
        end else begin
            if (!memStall) begin
                valid_EXMEM     <= validIn;
                result_EXMEM    <= result;
                storeData_EXMEM <= storeData;
                rd_EXMEM        <= rd_IDEX;
                regWrite_EXMEM  <= validIn & regWrite_IDEX & (rd_IDEX != REG_ZERO);
                memRead_EXMEM   <= memRead_IDEX;
                memWrite_EXMEM  <= memWrite_IDEX;
                memToReg_EXMEM  <= memToReg_IDEX;
            end
            // a stalled access or an abandoned load leaves a bubble in write-back
            if (memStall || (abort && memRead_EXMEM)) begin
                regWrite_MEMWB <= 1'b0;
            end else begin
                rd_MEMWB       <= rd_EXMEM;
                regWrite_MEMWB <= regWrite_EXMEM;
                valueToWB      <= memToReg_EXMEM ? mem.memReadData : result_EXMEM;
            end
        end
    end
`ifdef MEM_WB_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) stallCount <= '0;
        else if ((memStall || loadUseStall) && stallCount != '1) stallCount <= stallCount + 1'b1;
    end
`endif
endmodule
